// File: rtl/stream_tx_arbiter_if.sv
// Byte-stream bundle shared by the requesters, the TX arbiter and the TX FIFO input.
// master is the arbiter's view; slave is the view of the logic around it.
interface stream_tx_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0]   s_valid_i;
  logic [NUM_SRC-1:0]   s_ready_o;
  logic [8*NUM_SRC-1:0] s_data_i;
  logic [NUM_SRC-1:0]   s_last_i;
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic [7:0]           m_data_o;
  logic                 m_last_o;

  modport master (
    input  s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o
  );

  modport slave (
    output s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o
  );
endinterface

// File: rtl/stream_tx_arbiter.sv
// Packet-granular round-robin arbiter onto one byte stream; 1-cycle grant, then zero-latency pass-through.
// Non-owners see ready=0; owner sees m_ready directly; a stalled owner is released by the watchdog.
module stream_tx_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  stream_tx_arbiter_if.master bus,
  output logic [NUM_SRC-1:0]  grant_o,
  output logic                abort_o
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               abort_q, abort_d;

  logic               own_vld, own_last;
  logic [7:0]         own_dat;
  logic [IDX_W-1:0]   own_idx;
  logic [NUM_SRC-1:0] win_oh;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               hs, tmo;

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return IDX_W'(s);
  endfunction

  // grant_q is all-zero in IDLE, so the owner mux also yields an idle bus there
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_dat  = '0;
    own_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q[k]) begin
        own_vld  = bus.s_valid_i[k];
        own_last = bus.s_last_i[k];
        own_dat  = bus.s_data_i[8*k +: 8];
        own_idx  = IDX_W'(k);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = rot_idx(last_q, i);
      if (!found && bus.s_valid_i[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
      end
    end
  end

  assign bus.m_valid_o = own_vld;
  assign bus.m_data_o  = own_dat;
  assign bus.m_last_o  = own_last;
  assign bus.s_ready_o = grant_q & {NUM_SRC{bus.m_ready_i}};

  assign hs  = own_vld & bus.m_ready_i;
  assign tmo = (TIMEOUT > 0) && (state_q == BUSY) && !own_vld && (timer_q == TMR_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = win_oh;
          timer_d = '0;
        end
      end
      BUSY: begin
        if (hs && own_last) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = own_idx;
          timer_d = '0;
        end else if (tmo) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = own_idx;
          timer_d = '0;
          abort_d = 1'b1;
        end else if (own_vld) begin
          // backpressure with data pending is not a stall
          timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_LAST;
      timer_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      abort_q <= abort_d;
    end
  end

  assign grant_o = grant_q;
  assign abort_o = abort_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant_q));
  a_idle_no_grant: assert property (@(posedge clk) disable iff (!reset_n)
                                    (state_q == IDLE) |-> (grant_q == '0));
  a_busy_has_grant: assert property (@(posedge clk) disable iff (!reset_n)
                                     (state_q == BUSY) |-> (grant_q != '0));
endmodule

// File: tb/tb_stream_tx_arbiter.sv
// Bench for stream_tx_arbiter: directed scenarios plus randomized traffic against a
// packet/owner-level reference model, compared every cycle.
module tb_stream_tx_arbiter;
  localparam int N   = 2;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] grant;
  logic         abort;

  stream_tx_arbiter_if #(.NUM_SRC(N)) bus ();
  stream_tx_arbiter #(.NUM_SRC(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .grant_o(grant), .abort_o(abort)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic [N-1:0] sv = '0, sl = '0, en = '0;
  logic [7:0]   sd [N];
  logic         mr = 1'b1, rn = 1'b0;
  bit           rand_mode = 1'b0;
  logic [8:0]   q [N][$];

  // reference model: current owner (-1 = none), last owner, consecutive stall cycles
  int own = -1, lastg = N - 1, idle_run = 0;
  bit ab = 1'b0;
  bit hs_seen;
  int hs_src;

  logic [N-1:0] obs_gnt, obs_rdy;
  logic         obs_vld, obs_hs, obs_last, obs_abort;
  logic [7:0]   obs_dat;
  logic [7:0]   log_dat[$];
  int           log_cyc[$];
  logic         log_last[$];
  logic [N-1:0] log_gnt[$];
  int ab_cnt = 0, del_cnt = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d: cycle budget expired", name, cyc);
  endtask

  task automatic step();
    logic [N-1:0] e_gnt, e_rdy;
    logic         e_vld, e_last;
    logic [7:0]   e_dat;
    int           c, nxt;
    bit           got;
    @(negedge clk);
    reset_n       = rn;
    bus.s_valid_i = sv;
    bus.s_last_i  = sl;
    bus.m_ready_i = mr;
    for (int k = 0; k < N; k++) bus.s_data_i[8*k +: 8] = sd[k];
    #1;
    e_gnt = '0; e_rdy = '0; e_vld = 1'b0; e_last = 1'b0; e_dat = '0;
    if (own >= 0) begin
      e_gnt[own] = 1'b1;
      e_rdy[own] = mr;
      e_vld      = sv[own];
      e_last     = sl[own];
      e_dat      = sd[own];
    end
    obs_gnt   = grant;
    obs_rdy   = bus.s_ready_o;
    obs_vld   = bus.m_valid_o;
    obs_dat   = bus.m_data_o;
    obs_last  = bus.m_last_o;
    obs_abort = abort;
    obs_hs    = bus.m_valid_o & mr;
    if (chk_en) begin
      chk("grant", obs_gnt, e_gnt);
      chk("abort", obs_abort, ab);
      chk("m_valid", obs_vld, e_vld);
      chk("m_data", obs_dat, e_dat);
      chk("m_last", obs_last, e_last);
      chk("s_ready", obs_rdy, e_rdy);
    end
    hs_seen = e_vld && mr;
    hs_src  = own;
    ab      = 1'b0;
    if (rn !== 1'b1) begin
      own = -1; lastg = N - 1; idle_run = 0;
    end else if (own < 0) begin
      got = 1'b0; nxt = 0;
      for (int i = 1; i <= N; i++) begin
        c = (lastg + i) % N;
        if (!got && sv[c]) begin got = 1'b1; nxt = c; end
      end
      if (got) begin own = nxt; idle_run = 0; end
    end else if (sv[own] && mr && sl[own]) begin
      lastg = own; own = -1;
    end else if (sv[own]) begin
      idle_run = 0;
    end else begin
      idle_run++;
      if (TMO > 0 && idle_run == TMO) begin
        lastg = own; own = -1; ab = 1'b1; idle_run = 0;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (q[k].size() == 0 || !en[k]) begin
        sv[k] = 1'b0; sd[k] = '0; sl[k] = 1'b0;
      end else begin
        if (!rand_mode)  sv[k] = 1'b1;
        else if (sv[k])  sv[k] = ($urandom_range(0, 15) != 0);
        else             sv[k] = ($urandom_range(0, 3) != 0);
        sd[k] = q[k][0][7:0];
        sl[k] = q[k][0][8];
      end
    end
    if (rand_mode) mr = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cycle();
    drive();
    step();
    if (hs_seen) void'(q[hs_src].pop_front());
    if (obs_hs) begin
      log_dat.push_back(obs_dat);
      log_cyc.push_back(cyc - 1);
      log_last.push_back(obs_last);
      log_gnt.push_back(obs_gnt);
      del_cnt++;
    end
    if (obs_abort) ab_cnt++;
  endtask

  task automatic clear_log();
    log_dat.delete(); log_cyc.delete(); log_last.delete(); log_gnt.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && i < budget) begin
      cycle();
      i++;
    end
    if (q[0].size() != 0 || q[1].size() != 0) bound_fail(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] exp2 [12];
    int i, hs_c, ab_c;
    for (int k = 0; k < N; k++) sd[k] = '0;
    rn = 1'b0; chk_en = 1'b0;
    cycle(); cycle();
    chk_en = 1'b1;

    // reset held with everyone requesting, then src 0 wins first; 3-byte packets alternate
    en = '1; rand_mode = 1'b0; mr = 1'b1;
    for (int p = 0; p < 2; p++) begin
      q[0].push_back({1'b0, 8'hA0}); q[0].push_back({1'b0, 8'hA1}); q[0].push_back({1'b1, 8'hA2});
      q[1].push_back({1'b0, 8'hB0}); q[1].push_back({1'b0, 8'hB1}); q[1].push_back({1'b1, 8'hB2});
    end
    clear_log();
    for (int r = 0; r < 3; r++) begin
      cycle();
      chk("rst_grant", obs_gnt, 0);
      chk("rst_valid", obs_vld, 0);
      chk("rst_ready", obs_rdy, 0);
      chk("rst_data", obs_dat, 0);
    end
    rn = 1'b1;
    cycle();
    chk("post_rst_idle_grant", obs_gnt, 0);
    cycle();
    chk("post_rst_first_grant", obs_gnt, 2'b01);
    drain("alt_drain", 60);
    exp2 = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2,
             8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    chk("alt_count", log_dat.size(), 12);
    for (int b = 0; b < 12 && b < log_dat.size(); b++) begin
      chk("alt_byte", log_dat[b], exp2[b]);
      if (b > 0) chk("alt_gap", log_cyc[b] - log_cyc[b-1], (b % 3 == 0) ? 2 : 1);
    end

    // src 0 alone under ready toggling every cycle
    en = 2'b01; clear_log(); ab_cnt = 0;
    for (int b = 0; b < 50; b++) q[0].push_back({(b == 49), 8'(b)});
    i = 0;
    while (q[0].size() != 0 && i < 300) begin
      mr = i[0];
      cycle();
      i++;
    end
    if (q[0].size() != 0) bound_fail("toggle_drain");
    mr = 1'b1;
    chk("toggle_count", log_dat.size(), 50);
    for (int b = 0; b < 50 && b < log_dat.size(); b++) chk("toggle_byte", log_dat[b], b);
    chk("toggle_no_abort", ab_cnt, 0);

    // owner stalls mid-packet, watchdog releases, pending src 1 follows
    en = 2'b01; clear_log(); ab_cnt = 0;
    q[0].push_back({1'b0, 8'h40}); q[0].push_back({1'b0, 8'h41});
    drain("stall_send", 20);
    hs_c = (log_cyc.size() > 0) ? log_cyc[log_cyc.size()-1] : 0;
    en = 2'b11;
    q[1].push_back({1'b1, 8'h51});
    i = 0; ab_c = -1;
    while (ab_c < 0 && i < 30) begin
      cycle();
      if (obs_abort) begin
        ab_c = cyc - 1;
        chk("abort_cycle_grant", obs_gnt, 0);
      end
      i++;
    end
    if (ab_c < 0) bound_fail("abort_wait");
    // abort rises on the 8th edge after the last handshake edge
    chk("abort_delay", ab_c - hs_c, 9);
    cycle();
    chk("after_abort_grant", obs_gnt, 2'b10);
    drain("stall_drain", 20);
    chk("abort_once", ab_cnt, 1);

    // single requester, single-byte packets
    en = 2'b10; clear_log();
    for (int b = 0; b < 4; b++) q[1].push_back({1'b1, 8'h60 + 8'(b)});
    drain("single_drain", 30);
    chk("single_count", log_dat.size(), 4);
    for (int b = 0; b < 4 && b < log_dat.size(); b++) begin
      chk("single_grant", log_gnt[b], 2'b10);
      chk("single_last", log_last[b], 1);
      if (b > 0) chk("single_period", log_cyc[b] - log_cyc[b-1], 2);
    end

    // reset while src 1 would be next in rotation: arbitration restarts at src 0
    en = 2'b01; clear_log();
    for (int b = 0; b < 5; b++) q[0].push_back({(b == 4), 8'h70 + 8'(b)});
    i = 0;
    while (log_dat.size() < 2 && i < 20) begin cycle(); i++; end
    if (log_dat.size() < 2) bound_fail("midpkt_wait");
    rn = 1'b0;
    cycle();
    rn = 1'b1; en = 2'b11;
    q[1].push_back({1'b1, 8'h80});
    cycle();
    chk("midrst_grant", obs_gnt, 0);
    chk("midrst_ready", obs_rdy, 0);
    cycle();
    chk("midrst_regrant", obs_gnt, 2'b01);
    drain("midrst_drain", 40);

    // randomized traffic
    rand_mode = 1'b1; en = 2'b11; del_cnt = 0; total = 0;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < 40; p++) begin
        int len;
        len = $urandom_range(1, 5);
        for (int b = 0; b < len; b++) begin
          q[k].push_back({(b == len - 1), 8'($urandom)});
          total++;
        end
      end
    end
    drain("rand_drain", 20000);
    chk("rand_bytes", del_cnt, total);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
